// File: rtl/hack_screen_scanner.sv
// Hack screen reader: fetches screen RAM words in raster order and serializes
// them LSB-first into a 1-bit pixel stream with valid/ready handshake.
module hack_screen_scanner #(
  parameter int unsigned WORDS_PER_LINE = 32,
  parameter int unsigned LINES          = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        mem_rd,
  output logic [12:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sol,
  output logic        sof,
  output logic        frame_done
);

  localparam int unsigned NWORDS = WORDS_PER_LINE * LINES;
  localparam int unsigned NCOLS  = WORDS_PER_LINE * 16;
  localparam int unsigned CW     = $clog2(NCOLS);
  localparam int unsigned RW     = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [13:0]   W_END    = 14'(NWORDS);
  localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [13:0]   r_word_idx;
  logic          r_pend;
  logic [15:0]   r_sr;
  logic [4:0]    r_sr_cnt;
  logic [15:0]   r_buf;
  logic          r_buf_full;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_frame_done;

  logic w_rd;
  logic w_xfer;
  logic w_sr_last;
  logic w_last_pix;

  assign pix_valid  = (r_sr_cnt != '0);
  assign pix        = r_sr[0];
  assign sol        = pix_valid && (r_col == '0);
  assign sof        = sol && (r_row == '0);
  assign frame_done = r_frame_done;

  // r_pend marks the cycle after the strobe, when data is due on the next edge
  assign w_rd       = (r_state == S_RUN) && (r_word_idx != W_END) && !r_pend &&
                      (!pix_valid || !r_buf_full);
  assign mem_rd     = w_rd;
  assign mem_addr   = w_rd ? r_word_idx[12:0] : '0;

  assign w_xfer     = pix_valid && pix_ready;
  assign w_sr_last  = (r_sr_cnt == 5'd1);
  assign w_last_pix = (r_col == COL_LAST) && (r_row == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_word_idx   <= '0;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pend       <= w_rd;
      r_frame_done <= w_xfer && w_last_pix;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_RUN;
            r_word_idx <= '0;
          end
        end
        default: begin
          if (w_xfer && w_last_pix) begin
            if (en) r_word_idx <= '0;
            else    r_state    <= S_IDLE;
          end else if (w_rd) begin
            r_word_idx <= r_word_idx + 14'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // On the last-bit transfer the buffer reloads the shifter and any returning
  // word refills the buffer in the same edge, keeping the stream gapless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_sr_cnt   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_xfer && w_sr_last) begin
      if (r_buf_full) begin
        r_sr       <= r_buf;
        r_sr_cnt   <= 5'd16;
        r_buf_full <= r_pend;
        if (r_pend) r_buf <= mem_data;
      end else if (r_pend) begin
        r_sr     <= mem_data;
        r_sr_cnt <= 5'd16;
      end else begin
        r_sr     <= r_sr >> 1;
        r_sr_cnt <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_sr     <= r_sr >> 1;
        r_sr_cnt <= r_sr_cnt - 5'd1;
      end
      if (r_pend) begin
        if (!pix_valid) begin
          r_sr     <= mem_data;
          r_sr_cnt <= 5'd16;
        end else begin
          r_buf      <= mem_data;
          r_buf_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Scoreboard bench for hack_screen_scanner on a 2x2-word screen (64 pixels/frame).
module tb_hack_screen_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] mem_data = '0;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic        pix;
  logic        pix_valid;
  logic        sol;
  logic        sof;
  logic        frame_done;

  hack_screen_scanner #(.WORDS_PER_LINE(2), .LINES(2)) dut (
    .clk(clk), .reset(reset), .en(en),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sol(sol), .sof(sof), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_arr [4];
  always @(posedge clk) if (mem_rd) mem_data <= mem_arr[mem_addr[1:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int fd_count = 0;
  int pix_count = 0;
  logic [2:0]  exp_q [$];
  logic [12:0] exp_a [$];
  logic        rnd_on = 1'b0;
  logic        exp_a5 [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " pix"}, pix, 0);
    chk({tag, " pix_valid"}, pix_valid, 0);
    chk({tag, " sol"}, sol, 0);
    chk({tag, " sof"}, sof, 0);
    chk({tag, " frame_done"}, frame_done, 0);
  endtask

  task automatic push_frame(input logic use_table);
    logic [15:0] w;
    logic        b;
    for (int p = 0; p < 64; p++) begin
      w = mem_arr[p / 16];
      b = use_table ? exp_a5[p % 16] : w[p % 16];
      exp_q.push_back({b, (p % 32) == 0, p == 0});
    end
    for (int a = 0; a < 4; a++) exp_a.push_back(13'(a));
  endtask

  task automatic clear_counts();
    rd_count = 0;
    fd_count = 0;
    pix_count = 0;
  endtask

  task automatic pulse_en();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_a.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain timeout", exp_q.size() + exp_a.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_pix(input int n, input int budget);
    int c;
    c = 0;
    while (pix_count < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_pix timeout", pix_count >= n, 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a transfer.
  initial begin
    logic [2:0]  e;
    logic [12:0] ea;
    logic        prev_stall;
    logic [2:0]  prev_pss;
    prev_stall = 1'b0;
    prev_pss   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_rd) begin
          rd_count++;
          if (exp_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected mem_rd: addr %0h, none required at %0t", mem_addr, $time);
          end else begin
            ea = exp_a.pop_front();
            chk("mem_addr", mem_addr, ea);
          end
        end
        if (prev_stall) begin
          chk("stall valid held", pix_valid, 1);
          chk("stall pix/sol/sof held", {pix, sol, sof}, prev_pss);
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected pixel: got %0h, none required at %0t", {pix, sol, sof}, $time);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("pixel %0d pix/sol/sof", pix_count), {pix, sol, sof}, e);
          end
          pix_count++;
        end
        if (frame_done) fd_count++;
        prev_stall = pix_valid && !pix_ready;
        prev_pss   = {pix, sol, sof};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 if (rnd_on) pix_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int c;

    // Asynchronous reset mid-cycle, before any clock edge
    #3 reset = 1'b1;
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single frame, en pulsed
    for (int i = 0; i < 4; i++) mem_arr[i] = 16'h0001 << i;
    pix_ready = 1'b1;
    clear_counts();
    push_frame(1'b0);
    pulse_en();
    drain(300);
    chk("t2 mem_rd count", rd_count, 4);
    chk("t2 frame_done count", fd_count, 1);
    chk("t2 pixel count", pix_count, 64);
    chk("t2 idle valid", pix_valid, 0);

    // Throughput with en held, two frames
    clear_counts();
    push_frame(1'b0);
    push_frame(1'b0);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3 latency cyc0 valid", pix_valid, 0);
    chk("t3 latency cyc0 mem_rd", mem_rd, 1);
    @(negedge clk);
    chk("t3 latency cyc1 valid", pix_valid, 0);
    @(negedge clk);
    chk("t3 latency cyc2 valid", pix_valid, 1);
    run = 1;
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (pix_valid) run++;
      else break;
    end
    chk("t3 continuous valid run", run, 64);
    wait_pix(74, 200);
    en = 1'b0;
    drain(300);
    chk("t3 mem_rd count", rd_count, 8);
    chk("t3 frame_done count", fd_count, 2);

    // Random back-pressure, constant pattern
    for (int i = 0; i < 4; i++) mem_arr[i] = 16'hA5C3;
    clear_counts();
    push_frame(1'b1);
    rnd_on = 1'b1;
    pulse_en();
    drain(2000);
    rnd_on = 1'b0;
    pix_ready = 1'b1;
    chk("t4 mem_rd count", rd_count, 4);
    chk("t4 frame_done count", fd_count, 1);

    // en dropped mid-frame
    mem_arr[0] = 16'h8001;
    mem_arr[1] = 16'h00FF;
    mem_arr[2] = 16'hF0F0;
    mem_arr[3] = 16'h1234;
    clear_counts();
    push_frame(1'b0);
    @(posedge clk); #1 en = 1'b1;
    wait_pix(20, 200);
    en = 1'b0;
    drain(300);
    chk("t5 pixel count", pix_count, 64);
    chk("t5 mem_rd count", rd_count, 4);
    chk("t5 frame_done count", fd_count, 1);

    // Reset with a read outstanding, then restart
    clear_counts();
    push_frame(1'b0);
    pulse_en();
    c = 0;
    while (!(mem_rd && mem_addr == 13'd3) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t6 addr3 read seen", mem_rd && mem_addr == 13'd3, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("t6 reset");
    exp_q.delete();
    exp_a.delete();
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6 quiet after reset", {pix_valid, mem_rd}, 0);
    end
    clear_counts();
    push_frame(1'b0);
    pulse_en();
    drain(300);
    chk("t6 mem_rd count", rd_count, 4);
    chk("t6 frame_done count", fd_count, 1);
    chk("t6 pixel count", pix_count, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
